// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle: register addresses and control bits
// flowing in from the pipeline, stall/flush/forward controls flowing back.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic [REG_ADDR_WIDTH-1:0] rs1D_i;
  logic [REG_ADDR_WIDTH-1:0] rs2D_i;
  logic [REG_ADDR_WIDTH-1:0] rs1E_i;
  logic [REG_ADDR_WIDTH-1:0] rs2E_i;
  logic [REG_ADDR_WIDTH-1:0] rdE_i;
  logic                      regWriteE_i;
  logic                      resultSrcE_i;
  logic [REG_ADDR_WIDTH-1:0] rdM_i;
  logic                      regWriteM_i;
  logic [REG_ADDR_WIDTH-1:0] rdW_i;
  logic                      regWriteW_i;
  logic                      branchTakenE_i;
  logic                      memBusy_i;
  logic                      stallF_o;
  logic                      stallD_o;
  logic                      stallE_o;
  logic                      stallM_o;
  logic                      flushD_o;
  logic                      flushE_o;
  logic [1:0]                forwardAE_o;
  logic [1:0]                forwardBE_o;
  logic [1:0]                state_o;
  logic [CNT_WIDTH-1:0]      bubbleCnt_o;

  // Pipeline side: drives hazard sources, consumes controls.
  modport master (
    output rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, regWriteE_i, resultSrcE_i,
           rdM_i, regWriteM_i, rdW_i, regWriteW_i, branchTakenE_i, memBusy_i,
    input  stallF_o, stallD_o, stallE_o, stallM_o, flushD_o, flushE_o,
           forwardAE_o, forwardBE_o, state_o, bubbleCnt_o
  );

  // Hazard controller side.
  modport slave (
    input  rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, regWriteE_i, resultSrcE_i,
           rdM_i, regWriteM_i, rdW_i, regWriteW_i, branchTakenE_i, memBusy_i,
    output stallF_o, stallD_o, stallE_o, stallM_o, flushD_o, flushE_o,
           forwardAE_o, forwardBE_o, state_o, bubbleCnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Central stall/flush/forward controller for the five-stage pipeline.
// State advances on the falling clock edge, in step with the pipeline registers.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLUSH_CYCLES   = 2,
  parameter int CNT_WIDTH      = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t               state, state_nxt, eff;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 ret_flush, ret_nxt;
  logic [CNT_WIDTH-1:0] bubble;
  logic                 lu, stall_fd, stall_em, fl_d, fl_e, bump;
  logic [1:0]           fwd_a, fwd_b;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic [REG_ADDR_WIDTH-1:0] rdm,
    input logic                      wm,
    input logic [REG_ADDR_WIDTH-1:0] rdw,
    input logic                      ww
  );
    if (wm && rdm != '0 && rdm == rs) return 2'b10;
    if (ww && rdw != '0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Load-use detection and operand forwarding selects.
  always_comb begin
    lu = bus.resultSrcE_i && bus.regWriteE_i && (bus.rdE_i != '0) &&
         ((bus.rdE_i == bus.rs1D_i) || (bus.rdE_i == bus.rs2D_i));
    fwd_a = fwd_sel(bus.rs1E_i, bus.rdM_i, bus.regWriteM_i, bus.rdW_i, bus.regWriteW_i);
    fwd_b = fwd_sel(bus.rs2E_i, bus.rdM_i, bus.regWriteM_i, bus.rdW_i, bus.regWriteW_i);
  end

  // Control decode and next-state; on the memBusy fall cycle the return
  // state's rules are applied directly by substituting it as the effective state.
  always_comb begin
    stall_fd  = 1'b0;
    stall_em  = 1'b0;
    fl_d      = 1'b0;
    fl_e      = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    ret_nxt   = ret_flush;
    eff       = state;
    if (state == MEMWAIT && !bus.memBusy_i) eff = ret_flush ? FLUSH : RUN;
    case (eff)
      RUN: begin
        if (bus.memBusy_i) begin
          stall_fd  = 1'b1;
          stall_em  = 1'b1;
          state_nxt = MEMWAIT;
          ret_nxt   = 1'b0;
        end else if (bus.branchTakenE_i) begin
          fl_d = 1'b1;
          fl_e = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            cnt_nxt   = CW'(FLUSH_CYCLES - 1);
          end else begin
            state_nxt = RUN;
          end
        end else if (lu) begin
          stall_fd  = 1'b1;
          fl_e      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        if (bus.memBusy_i) begin
          stall_fd  = 1'b1;
          stall_em  = 1'b1;
          state_nxt = MEMWAIT;
          ret_nxt   = 1'b1;
        end else begin
          fl_d      = 1'b1;
          cnt_nxt   = cnt - CW'(1);
          state_nxt = (cnt <= CW'(1)) ? RUN : FLUSH;
        end
      end
      default: begin
        stall_fd  = 1'b1;
        stall_em  = 1'b1;
        state_nxt = MEMWAIT;
      end
    endcase
    bump = fl_e | stall_fd | fl_d;
  end

  // Output drive; reset forces bubbles into decode/execute and silences the rest.
  always_comb begin
    bus.stallF_o    = stall_fd & ~rst;
    bus.stallD_o    = stall_fd & ~rst;
    bus.stallE_o    = stall_em & ~rst;
    bus.stallM_o    = stall_em & ~rst;
    bus.flushD_o    = fl_d | rst;
    bus.flushE_o    = fl_e | rst;
    bus.forwardAE_o = rst ? 2'b00 : fwd_a;
    bus.forwardBE_o = rst ? 2'b00 : fwd_b;
    bus.state_o     = state;
    bus.bubbleCnt_o = bubble;
  end

  // FSM, flush-window counter, return flag and saturating bubble counter.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      ret_flush <= 1'b0;
      bubble    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ret_flush <= ret_nxt;
      if (bump && bubble != '1) bubble <= bubble + CNT_WIDTH'(1);
    end
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Central stall/flush/forward controller for the five-stage RISC-V pipeline.
- Watches register addresses and control bits from decode, execute, memory and writeback.
- Drives the stall and flush enables of the fetch, decode and execute pipeline registers and the execute-stage forwarding muxes.
- Sequences multi-cycle events (taken-branch flush windows, data-memory wait) and counts lost cycles for performance analysis.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register-file address width
- FLUSH_CYCLES, 2, cycles decode is flushed after a taken branch/jump (≥1; covers registered instruction-memory wrong-path fetches)
- CNT_WIDTH, 16, width of the bubble counter

Ports (clock and reset first). Reset is asynchronous and active-high.
- clk  in  1  system clock; all state updates on the falling edge, matching the pipeline registers
- rst  in  1  asynchronous reset, active-high
- rs1D_i, rs2D_i  in  REG_ADDR_WIDTH  source registers of the decode-stage instruction
- rs1E_i, rs2E_i  in  REG_ADDR_WIDTH  source registers of the execute-stage instruction
- rdE_i  in  REG_ADDR_WIDTH  destination register in execute
- regWriteE_i  in  1  execute instruction writes the register file
- resultSrcE_i  in  1  execute instruction is a load
- rdM_i, regWriteM_i  in  REG_ADDR_WIDTH, 1  memory-stage destination and write enable
- rdW_i, regWriteW_i  in  REG_ADDR_WIDTH, 1  writeback-stage destination and write enable
- branchTakenE_i  in  1  taken branch, JAL or JALR resolved in execute
- memBusy_i  in  1  data memory not ready; pipeline must freeze
- stallF_o, stallD_o, stallE_o, stallM_o  out  1  hold the PC / decode / execute / memory registers
- flushD_o, flushE_o  out  1  clear the decode / execute registers to a bubble
- forwardAE_o, forwardBE_o  out  2  operand select: 00 register file, 01 writeback result, 10 memory ALU result
- state_o  out  2  FSM state: 0 RUN, 1 FLUSH, 2 MEMWAIT
- bubbleCnt_o  out  CNT_WIDTH  lost-cycle counter

## Operation
- **Load-use hazard (LU):** resultSrcE_i & regWriteE_i & rdE_i≠0 & (rdE_i==rs1D_i | rdE_i==rs2D_i).
- **Forwarding (combinational, every state):**
  - forwardAE_o = 10 if regWriteM_i & rdM_i≠0 & rdM_i==rs1E_i.
  - Otherwise 01 if regWriteW_i & rdW_i≠0 & rdW_i==rs1E_i.
  - Otherwise 00.
  - Memory stage wins over writeback. Same rules for forwardBE_o using rs2E_i.
- **RUN.** Priority, highest first:
  - memBusy_i: assert all four stalls and no flush; next state MEMWAIT.
  - branchTakenE_i: assert flushD_o and flushE_o; if FLUSH_CYCLES>1, load cnt=FLUSH_CYCLES-1 and go to FLUSH, else stay in RUN.
  - LU: assert stallF_o, stallD_o and flushE_o for one bubble; stay in RUN.
  - None of the above: all stall/flush outputs 0.
- **FLUSH:**
  - memBusy_i: all stalls asserted, flushD_o=0, cnt holds; next state MEMWAIT, then return to FLUSH with the held cnt.
  - Otherwise: flushD_o=1, flushE_o=0, cnt decrements; go to RUN when cnt reaches 1→0.
  - LU and branchTakenE_i are ignored, because the decode/execute contents are wrong-path or bubbles.
- **MEMWAIT:**
  - While memBusy_i=1: all four stalls asserted, no flush, cnt frozen.
  - In the first cycle with memBusy_i=0: outputs and next state are evaluated using the rules of the return state. That state is RUN, or FLUSH if MEMWAIT was entered from FLUSH (the return state is stored in a 1-bit register).
- **bubbleCnt_o:** increments by 1 on each falling edge where flushE_o | stallD_o | flushD_o is asserted; saturates at all-ones.
- **Reset (rst=1), asynchronous:**
  - state RUN, cnt 0, return-flag 0, bubbleCnt_o 0.
  - Outputs while rst=1: stalls 0, flushD_o=flushE_o=1, forwards 00, state_o 0.

## Timing
- All stall, flush and forward outputs are combinational from the current state and inputs, valid before the next falling edge of clk.
- FSM, cnt and bubbleCnt_o update on the falling edge.
- A taken branch costs exactly FLUSH_CYCLES decode flushes plus 1 execute flush when memBusy_i stays low.
- A load-use bubble costs exactly 1 cycle.
- memBusy_i asserted for N cycles freezes the pipeline for exactly N cycles. The memBusy_i fall cycle is a normal cycle.
- x0 never causes forwarding or a stall.
- rst asserted mid-FLUSH or mid-MEMWAIT aborts immediately; the next cycle after release is RUN.

## Test plan
- **Load-use:** rdE=5, load, regWriteE=1, rs1D=5 → one cycle with stallF=stallD=flushE=1; next cycle all 0; bubbleCnt 0→1.
- **Taken branch, FLUSH_CYCLES=2:**
  - Branch cycle: flushD=flushE=1, state→FLUSH.
  - Next cycle: flushD=1 only, state→RUN.
  - Third cycle: all 0; bubbleCnt=2.
- **Forwarding priority:** rs1E=7, rdM=7/regWriteM=1 and rdW=7/regWriteW=1 → forwardAE=10; drop regWriteM → 01; rdM=rdW=0 with rs1E=0 → 00.
- **memBusy inside FLUSH:** memBusy=1 for 3 cycles starting in the FLUSH cycle → all stalls 1 and flushD 0 for 3 cycles, state_o=2; on memBusy fall, flushD=1 and state→RUN.
- **Reset mid-MEMWAIT:** rst pulse while memBusy=1 → state_o=0, bubbleCnt=0, flushD=flushE=1 during rst; after release with memBusy=0 all outputs 0.
- **Saturation:** CNT_WIDTH=4, 20 consecutive LU cycles → bubbleCnt_o stops at 15.
